execute_writeback: RTL and testbench
====================================

# execute_writeback

Final pipeline stage of the venus core: accepts decoded instructions from `decode_instruction` and computes ALU results. Returns results to `g_reg_x16` through its `wb_i` / `wb_r_i` / `result_i` write port, which also clears the reservation. Resolves jumps toward `fetch_instruction` through its `branch` / `branch_addr` inputs. It is the consumer end of the decode output interface and the producer end of the register-file writeback interface.

## Interface
- `WORD`, 32, datapath width
- `ADDR`, 16, instruction address width
- `W_OPC`, 6, opcode width
- `W_OPR`, 32, operand/result width
- `W_RD`, 4, register index width
- `clk` input 1: single clock.
- `reset` input 1: synchronous, active-high.
- `v_i` input 1: decode output valid.
- `stall_o` output 1: back-pressure to decode `stall_i`.
- `opecode_i` input W_OPC: decoded opcode.
- `opr0_i`, `opr1_i` input W_OPR: source operands.
- `wb_r_i` input W_RD: destination register.
- `pc_i` input ADDR: PC of the instruction (kept for tracing only).
- `wb_o` output 1: register write strobe, to `g_reg_x16.wb_i`.
- `wb_r_o` output W_RD: write index.
- `result_o` output W_OPR: write data.
- `branch_o` output 1: taken-branch strobe, to `fetch_instruction.branch`.
- `branch_addr_o` output ADDR: branch target.

## Operation
- Transfer occurs when `v_i && !stall_o`.
- Opcode map:
  - 0 NOP
  - 1 ADD
  - 2 SUB
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 SLL
  - 7 SRL (logical)
  - 8 MOV (result = opr0)
  - 9 JMP
  - 10 BEQZ
  - 11 MUL
- Any other opcode behaves as NOP.
- Arithmetic wraps modulo 2^W_OPR. Shift amount is `opr1[4:0]`.
- MUL result is the low W_OPR bits of the unsigned product.
- Ops 1–8 and 11 write back. NOP, JMP, BEQZ and unknown opcodes never assert `wb_o`.
- JMP: taken, target `opr0[ADDR-1:0]`.
- BEQZ: taken iff `opr0 == 0`, target `opr1[ADDR-1:0]`. When not taken, no strobe of any kind.
- No squashing: instructions already fetched/decoded behind a branch execute normally (architectural delay slots).
- FSM states:
  - IDLE: single-cycle ops complete here. Accepting MUL moves to MUL and latches operands and `wb_r`.
  - MUL: iterative shift-add, one multiplier bit per cycle, 32 iterations. After the last iteration it moves to DONE.
  - DONE: drives the writeback and returns to IDLE.

## Timing
- Reset values:
  - `wb_o=0`, `wb_r_o=0`, `result_o=0`
  - `branch_o=0`, `branch_addr_o=0`
  - `stall_o=0`, FSM=IDLE
  - multiplier registers cleared
- Single-cycle op accepted at edge N: `wb_o` (or `branch_o`) is high for exactly the cycle after edge N, with index and data valid in the same cycle.
- Back-to-back single-cycle ops sustain one writeback per cycle.
- `wb_o` and `branch_o` are one-cycle pulses. They are never both high, because no opcode does both.
- MUL accepted at edge N:
  - `stall_o` is high from after edge N until after edge N+33.
  - `wb_o` is high during the cycle following edge N+33, with `stall_o` low in that cycle, so a new instruction can be accepted at edge N+34.
- While `stall_o` is high, `v_i` and the operands are ignored. Decode must hold them.
- Reset mid-MUL: the FSM returns to IDLE on the next edge, no writeback is issued, and `stall_o` drops.
- `v_i` low: outputs return to 0 strobes. Data outputs may hold their last values.

## Configuration
- `VENUS_MUL_EN` defined: opcode 11 is implemented as above, with the FSM and stall.
- `VENUS_MUL_EN` undefined:
  - Opcode 11 is an unknown opcode and behaves as NOP, with no writeback.
  - `stall_o` is tied to 0.
  - The FSM and multiplier logic are not generated.

## Structure
- `include/params.v` holds:
  - width parameters (`WORD`, `ADDR`, `W_OPC`, `W_OPR`, `W_RD`)
  - opcode constants (`OPC_NOP` … `OPC_MUL`)
  - FSM state encodings
- The opcode constants are shared with `decode_instruction`.
- One sub-module, `mul_iter`: the iterative multiplier.
  - Inputs: start, a, b.
  - Outputs: busy, done, product.
  - Only instantiated under `VENUS_MUL_EN`.
- ALU and branch logic are in the top module.

## Test plan
- After reset: all outputs are 0. Send ADD with opr0=32'h00000005, opr1=32'h00000007, wb_r=2 → next cycle `wb_o=1`, `wb_r_o=2`, `result_o=32'h0000000C`, then `wb_o=0`.
- SUB with 32'h00000000 − 32'h00000001 → `result_o=32'hFFFFFFFF`. SLL with 32'h89abcdef by 4 → `result_o=32'h9abcdef0`.
- Back-to-back ADD, XOR, MOV on consecutive cycles → three consecutive `wb_o` pulses carrying the correct indices and data.
- JMP with opr0=16'h0040 → `branch_o=1`, `branch_addr_o=16'h0040`, `wb_o=0`. BEQZ with opr0=1 → no strobe. BEQZ with opr0=0, opr1=16'h0010 → branch to 16'h0010.
- MUL (`VENUS_MUL_EN`) of 32'h00010001 × 32'h0000FFFF, wb_r=3:
  - `stall_o` high for 33 cycles, then `wb_o=1` with `result_o=32'hFFFFFFFF`.
  - An ADD held on `v_i` during the stall is accepted only after the MUL writes back.
- Reset asserted 10 cycles into a MUL → no `wb_o`, `stall_o=0` on the next cycle. Without the macro, MUL produces no writeback and no stall.

Source files
------------

// File: rtl/execute_writeback_pkg.sv
// Shared widths, opcode map and FSM encoding for the venus execute/writeback stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package execute_writeback_pkg;

  localparam int WORD  = 32;
  localparam int ADDR  = 16;
  localparam int W_OPC = 6;
  localparam int W_OPR = 32;
  localparam int W_RD  = 4;

  // Opcode constants; decode_instruction uses the same map.
  localparam logic [W_OPC-1:0] OPC_NOP  = 6'd0;
  localparam logic [W_OPC-1:0] OPC_ADD  = 6'd1;
  localparam logic [W_OPC-1:0] OPC_SUB  = 6'd2;
  localparam logic [W_OPC-1:0] OPC_AND  = 6'd3;
  localparam logic [W_OPC-1:0] OPC_OR   = 6'd4;
  localparam logic [W_OPC-1:0] OPC_XOR  = 6'd5;
  localparam logic [W_OPC-1:0] OPC_SLL  = 6'd6;
  localparam logic [W_OPC-1:0] OPC_SRL  = 6'd7;
  localparam logic [W_OPC-1:0] OPC_MOV  = 6'd8;
  localparam logic [W_OPC-1:0] OPC_JMP  = 6'd9;
  localparam logic [W_OPC-1:0] OPC_BEQZ = 6'd10;
  localparam logic [W_OPC-1:0] OPC_MUL  = 6'd11;

  // Multiply sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/execute_writeback_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low W_OPR bits of the product.
// Latency: start at edge N, done_o high in the cycle after edge N+31, product_o valid after edge N+32.
// Backpressure: none; a start while busy restarts the operation.
module mul_iter
  import execute_writeback_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [W_OPR-1:0] a_i,
  input  logic [W_OPR-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [W_OPR-1:0] product_o
);

  logic [W_OPR-1:0] acc_q, acc_d;
  logic [W_OPR-1:0] mcand_q, mcand_d;
  logic [W_OPR-1:0] mplier_q, mplier_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d;

  // One shift-add step per cycle; the multiplicand shifts left, the multiplier right.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start_i) begin
      acc_d    = '0;
      mcand_d  = a_i;
      mplier_d = b_i;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        busy_d = 1'b0;
      end
    end
  end

  // Iteration state registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = busy_q && (cnt_q == 5'd31);
  assign product_o = acc_q;

endmodule

// File: rtl/execute_writeback.sv
// Final venus stage: ALU, branch resolve and register-file writeback (MUL gated by VENUS_MUL_EN).
// Latency: single-cycle ops strobe the cycle after acceptance; MUL writes back 34 edges after acceptance.
// Backpressure: stall_o held high while a MUL iterates; tied low when VENUS_MUL_EN is undefined.
module execute_writeback
  import execute_writeback_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             v_i,
  output logic             stall_o,
  input  logic [W_OPC-1:0] opecode_i,
  input  logic [W_OPR-1:0] opr0_i,
  input  logic [W_OPR-1:0] opr1_i,
  input  logic [W_RD-1:0]  wb_r_i,
  input  logic [ADDR-1:0]  pc_i,
  output logic             wb_o,
  output logic [W_RD-1:0]  wb_r_o,
  output logic [W_OPR-1:0] result_o,
  output logic             branch_o,
  output logic [ADDR-1:0]  branch_addr_o
);

  logic             accept;
  logic [W_OPR-1:0] alu_res;
  logic             alu_wb;
  logic             br_taken;
  logic [ADDR-1:0]  br_target;

  logic             wb_q;
  logic [W_RD-1:0]  wb_r_q;
  logic [W_OPR-1:0] result_q;
  logic             branch_q;
  logic [ADDR-1:0]  branch_addr_q;

  // The PC only travels with the instruction for trace purposes.
  logic unused_pc;
  assign unused_pc = ^pc_i;

  assign accept = v_i && !stall_o;

  // Single-cycle ALU and branch decision; MUL and unknown opcodes fall to the default (no strobe).
  always_comb begin
    alu_res   = '0;
    alu_wb    = 1'b0;
    br_taken  = 1'b0;
    br_target = '0;
    case (opecode_i)
      OPC_ADD:  begin alu_res = opr0_i + opr1_i;           alu_wb = 1'b1; end
      OPC_SUB:  begin alu_res = opr0_i - opr1_i;           alu_wb = 1'b1; end
      OPC_AND:  begin alu_res = opr0_i & opr1_i;           alu_wb = 1'b1; end
      OPC_OR:   begin alu_res = opr0_i | opr1_i;           alu_wb = 1'b1; end
      OPC_XOR:  begin alu_res = opr0_i ^ opr1_i;           alu_wb = 1'b1; end
      OPC_SLL:  begin alu_res = opr0_i << opr1_i[4:0];     alu_wb = 1'b1; end
      OPC_SRL:  begin alu_res = opr0_i >> opr1_i[4:0];     alu_wb = 1'b1; end
      OPC_MOV:  begin alu_res = opr0_i;                    alu_wb = 1'b1; end
      OPC_JMP:  begin br_taken = 1'b1;                     br_target = opr0_i[ADDR-1:0]; end
      OPC_BEQZ: begin br_taken = (opr0_i == '0);           br_target = opr1_i[ADDR-1:0]; end
      default:  ;
    endcase
  end

`ifdef VENUS_MUL_EN
  state_t           state_q, state_d;
  logic [W_RD-1:0]  mul_rd_q;
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [W_OPR-1:0] mul_product;

  assign stall_o   = (state_q != ST_IDLE);
  assign mul_start = accept && (opecode_i == OPC_MUL);

  mul_iter u_mul_iter (
    .clk_i     (clk),
    .reset_i   (reset),
    .start_i   (mul_start),
    .a_i       (opr0_i),
    .b_i       (opr1_i),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  // Next-state: IDLE -> MUL on accept, MUL -> DONE after the last iteration, DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mul_start) state_d = ST_MUL;
      ST_MUL: begin
        if (mul_done) begin
          state_d = ST_DONE;
        end else if (!mul_busy) begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and destination index held for the multiply writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      mul_rd_q <= '0;
    end else begin
      state_q <= state_d;
      if (mul_start) begin
        mul_rd_q <= wb_r_i;
      end
    end
  end
`else
  assign stall_o = 1'b0;
`endif

  // Output registers: strobes default low each cycle, data holds until the next strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_q          <= 1'b0;
      wb_r_q        <= '0;
      result_q      <= '0;
      branch_q      <= 1'b0;
      branch_addr_q <= '0;
    end else begin
      wb_q     <= 1'b0;
      branch_q <= 1'b0;
      if (accept && alu_wb) begin
        wb_q     <= 1'b1;
        wb_r_q   <= wb_r_i;
        result_q <= alu_res;
      end
      if (accept && br_taken) begin
        branch_q      <= 1'b1;
        branch_addr_q <= br_target;
      end
`ifdef VENUS_MUL_EN
      if (state_q == ST_DONE) begin
        wb_q     <= 1'b1;
        wb_r_q   <= mul_rd_q;
        result_q <= mul_product;
      end
`endif
    end
  end

  assign wb_o          = wb_q;
  assign wb_r_o        = wb_r_q;
  assign result_o      = result_q;
  assign branch_o      = branch_q;
  assign branch_addr_o = branch_addr_q;

endmodule

// File: tb/tb_execute_writeback.sv
// Self-checking bench for execute_writeback: directed cases plus randomized ops against a reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// MUL scenarios follow VENUS_MUL_EN as defined for the build.
module tb_execute_writeback;

  logic        clk;
  logic        reset;
  logic        v_i;
  logic        stall_o;
  logic [5:0]  opecode_i;
  logic [31:0] opr0_i;
  logic [31:0] opr1_i;
  logic [3:0]  wb_r_i;
  logic [15:0] pc_i;
  logic        wb_o;
  logic [3:0]  wb_r_o;
  logic [31:0] result_o;
  logic        branch_o;
  logic [15:0] branch_addr_o;

  int checks = 0;
  int errors = 0;

  execute_writeback dut (
    .clk           (clk),
    .reset         (reset),
    .v_i           (v_i),
    .stall_o       (stall_o),
    .opecode_i     (opecode_i),
    .opr0_i        (opr0_i),
    .opr1_i        (opr1_i),
    .wb_r_i        (wb_r_i),
    .pc_i          (pc_i),
    .wb_o          (wb_o),
    .wb_r_o        (wb_r_o),
    .result_o      (result_o),
    .branch_o      (branch_o),
    .branch_addr_o (branch_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: what one accepted instruction should produce, straight from the opcode map.
  function automatic void model(input logic [5:0] opc, input logic [31:0] a, input logic [31:0] b,
                                output bit wb, output logic [31:0] res,
                                output bit br, output logic [15:0] tgt);
    int sh;
    sh  = int'(b % 32);
    wb  = 1'b0;
    br  = 1'b0;
    res = 32'd0;
    tgt = 16'd0;
    case (int'(opc))
      1:  begin wb = 1'b1; res = a + b; end
      2:  begin wb = 1'b1; res = a - b; end
      3:  begin wb = 1'b1; res = a & b; end
      4:  begin wb = 1'b1; res = a | b; end
      5:  begin wb = 1'b1; res = a ^ b; end
      6:  begin wb = 1'b1; res = a << sh; end
      7:  begin wb = 1'b1; res = a >> sh; end
      8:  begin wb = 1'b1; res = a; end
      9:  begin br = 1'b1; tgt = a[15:0]; end
      10: begin br = (a == 32'd0); tgt = b[15:0]; end
      default: ;
    endcase
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] opc, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] rd);
    v_i       = 1'b1;
    opecode_i = opc;
    opr0_i    = a;
    opr1_i    = b;
    wb_r_i    = rd;
    pc_i      = 16'($urandom);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step; step; step;
    checks++; if (wb_o !== 1'b0)           begin errors++; $display("FAIL reset_wb: got %b want 0", wb_o); end
    checks++; if (wb_r_o !== 4'd0)         begin errors++; $display("FAIL reset_wb_r: got %0d want 0", wb_r_o); end
    checks++; if (result_o !== 32'd0)      begin errors++; $display("FAIL reset_result: got %h want 0", result_o); end
    checks++; if (branch_o !== 1'b0)       begin errors++; $display("FAIL reset_branch: got %b want 0", branch_o); end
    checks++; if (branch_addr_o !== 16'd0) begin errors++; $display("FAIL reset_baddr: got %h want 0", branch_addr_o); end
    checks++; if (stall_o !== 1'b0)        begin errors++; $display("FAIL reset_stall: got %b want 0", stall_o); end
    reset = 1'b0;
    step;
  endtask

  task automatic test_alu_directed;
    drive(6'd1, 32'h00000005, 32'h00000007, 4'd2);
    step;
    v_i = 1'b0;
    checks++; if (wb_o !== 1'b1)            begin errors++; $display("FAIL add_wb: got %b want 1", wb_o); end
    checks++; if (wb_r_o !== 4'd2)          begin errors++; $display("FAIL add_rd: got %0d want 2", wb_r_o); end
    checks++; if (result_o !== 32'h0000000C) begin errors++; $display("FAIL add_res: got %h want 0000000c", result_o); end
    step;
    checks++; if (wb_o !== 1'b0)            begin errors++; $display("FAIL add_pulse: got %b want 0", wb_o); end
    drive(6'd2, 32'h00000000, 32'h00000001, 4'd4);
    step;
    v_i = 1'b0;
    checks++; if (result_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL sub_wrap: got %h want ffffffff", result_o); end
    step;
    drive(6'd6, 32'h89abcdef, 32'h00000004, 4'd6);
    step;
    v_i = 1'b0;
    checks++; if (result_o !== 32'h9abcdef0) begin errors++; $display("FAIL sll: got %h want 9abcdef0", result_o); end
    step;
  endtask

  task automatic test_back_to_back;
    drive(6'd1, 32'd10, 32'd20, 4'd1);
    step;
    drive(6'd5, 32'hF0F0F0F0, 32'h0FF00FF0, 4'd7);
    checks++; if (wb_o !== 1'b1 || wb_r_o !== 4'd1 || result_o !== 32'd30)
      begin errors++; $display("FAIL b2b_add: got wb=%b rd=%0d res=%h want 1 1 0000001e", wb_o, wb_r_o, result_o); end
    step;
    drive(6'd8, 32'hDEADBEEF, 32'd0, 4'd9);
    checks++; if (wb_o !== 1'b1 || wb_r_o !== 4'd7 || result_o !== 32'hFF00FF00)
      begin errors++; $display("FAIL b2b_xor: got wb=%b rd=%0d res=%h want 1 7 ff00ff00", wb_o, wb_r_o, result_o); end
    step;
    v_i = 1'b0;
    checks++; if (wb_o !== 1'b1 || wb_r_o !== 4'd9 || result_o !== 32'hDEADBEEF)
      begin errors++; $display("FAIL b2b_mov: got wb=%b rd=%0d res=%h want 1 9 deadbeef", wb_o, wb_r_o, result_o); end
    step;
    checks++; if (wb_o !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", wb_o); end
  endtask

  task automatic test_branch;
    drive(6'd9, 32'h00000040, 32'd0, 4'd3);
    step;
    v_i = 1'b0;
    checks++; if (branch_o !== 1'b1 || branch_addr_o !== 16'h0040 || wb_o !== 1'b0)
      begin errors++; $display("FAIL jmp: got br=%b addr=%h wb=%b want 1 0040 0", branch_o, branch_addr_o, wb_o); end
    step;
    drive(6'd10, 32'd1, 32'h00000020, 4'd3);
    step;
    v_i = 1'b0;
    checks++; if (branch_o !== 1'b0 || wb_o !== 1'b0)
      begin errors++; $display("FAIL beqz_nt: got br=%b wb=%b want 0 0", branch_o, wb_o); end
    step;
    drive(6'd10, 32'd0, 32'h00000010, 4'd3);
    step;
    v_i = 1'b0;
    checks++; if (branch_o !== 1'b1 || branch_addr_o !== 16'h0010 || wb_o !== 1'b0)
      begin errors++; $display("FAIL beqz_t: got br=%b addr=%h wb=%b want 1 0010 0", branch_o, branch_addr_o, wb_o); end
    step;
    checks++; if (branch_o !== 1'b0) begin errors++; $display("FAIL br_pulse: got %b want 0", branch_o); end
  endtask

  task automatic test_random;
    logic [5:0]  opc;
    logic [31:0] a, b, eres;
    logic [15:0] etgt;
    logic [3:0]  rd;
    bit          ewb, ebr, bubble;
    for (int i = 0; i < 80; i++) begin
      opc = 6'($urandom_range(0, 63));
      if (opc == 6'd11) opc = 6'd1;
      a  = $urandom;
      b  = $urandom;
      if (opc == 6'd10 && $urandom_range(0, 1) == 1) a = 32'd0;
      rd = 4'($urandom);
      bubble = ($urandom_range(0, 4) == 0);
      drive(opc, a, b, rd);
      if (bubble) begin
        v_i = 1'b0;
        ewb = 1'b0; ebr = 1'b0; eres = 32'd0; etgt = 16'd0;
      end else begin
        model(opc, a, b, ewb, eres, ebr, etgt);
      end
      step;
      checks++; if (wb_o !== ewb) begin errors++; $display("FAIL rnd_wb[%0d] opc=%0d: got %b want %b", i, opc, wb_o, ewb); end
      checks++; if (branch_o !== ebr) begin errors++; $display("FAIL rnd_br[%0d] opc=%0d: got %b want %b", i, opc, branch_o, ebr); end
      if (ewb) begin
        checks++; if (wb_r_o !== rd || result_o !== eres)
          begin errors++; $display("FAIL rnd_data[%0d] opc=%0d: got rd=%0d res=%h want %0d %h", i, opc, wb_r_o, result_o, rd, eres); end
      end
      if (ebr) begin
        checks++; if (branch_addr_o !== etgt)
          begin errors++; $display("FAIL rnd_tgt[%0d]: got %h want %h", i, branch_addr_o, etgt); end
      end
    end
    v_i = 1'b0;
    step;
  endtask

`ifdef VENUS_MUL_EN
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [3:0] rd, input string tag);
    int  cnt;
    bit  early_wb;
    logic [31:0] exp;
    exp = a * b;
    drive(6'd11, a, b, rd);
    step;
    // A held ADD sits on the inputs for the whole stall.
    drive(6'd1, 32'd1, 32'd2, 4'd5);
    cnt = 0;
    early_wb = 1'b0;
    while (stall_o === 1'b1 && cnt < 40) begin
      if (wb_o !== 1'b0) early_wb = 1'b1;
      cnt++;
      step;
    end
    checks++; if (cnt != 33) begin errors++; $display("FAIL %s_stall_len: got %0d want 33", tag, cnt); end
    checks++; if (early_wb) begin errors++; $display("FAIL %s_early_wb: got wb during stall want none", tag); end
    checks++; if (wb_o !== 1'b1 || wb_r_o !== rd || result_o !== exp)
      begin errors++; $display("FAIL %s_wb: got wb=%b rd=%0d res=%h want 1 %0d %h", tag, wb_o, wb_r_o, result_o, rd, exp); end
    step;
    v_i = 1'b0;
    checks++; if (wb_o !== 1'b1 || wb_r_o !== 4'd5 || result_o !== 32'd3)
      begin errors++; $display("FAIL %s_held_add: got wb=%b rd=%0d res=%h want 1 5 00000003", tag, wb_o, wb_r_o, result_o); end
    step;
  endtask

  task automatic test_mul;
    run_mul(32'h00010001, 32'h0000FFFF, 4'd3, "mul_dir");
    for (int i = 0; i < 3; i++) begin
      run_mul($urandom, $urandom, 4'($urandom_range(0, 15)), "mul_rnd");
    end
  endtask

  task automatic test_mul_reset;
    bit seen_wb;
    drive(6'd11, 32'h12345678, 32'h9ABCDEF0, 4'd8);
    step;
    v_i = 1'b0;
    for (int i = 0; i < 10; i++) step;
    reset = 1'b1;
    step;
    checks++; if (stall_o !== 1'b0 || wb_o !== 1'b0)
      begin errors++; $display("FAIL mulrst_now: got stall=%b wb=%b want 0 0", stall_o, wb_o); end
    reset = 1'b0;
    seen_wb = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (wb_o !== 1'b0 || stall_o !== 1'b0) seen_wb = 1'b1;
      step;
    end
    checks++; if (seen_wb) begin errors++; $display("FAIL mulrst_after: got late wb/stall want none"); end
  endtask
`else
  task automatic test_mul;
    bit seen;
    drive(6'd11, 32'h00010001, 32'h0000FFFF, 4'd3);
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL nomul_stall_pre: got %b want 0", stall_o); end
    step;
    v_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (wb_o !== 1'b0 || stall_o !== 1'b0 || branch_o !== 1'b0) seen = 1'b1;
      step;
    end
    checks++; if (seen) begin errors++; $display("FAIL nomul: got strobe or stall want none"); end
  endtask

  task automatic test_mul_reset;
    reset = 1'b1;
    step;
    checks++; if (stall_o !== 1'b0 || wb_o !== 1'b0)
      begin errors++; $display("FAIL nomul_rst: got stall=%b wb=%b want 0 0", stall_o, wb_o); end
    reset = 1'b0;
    step;
  endtask
`endif

  initial begin
    reset     = 1'b1;
    v_i       = 1'b0;
    opecode_i = 6'd0;
    opr0_i    = 32'd0;
    opr1_i    = 32'd0;
    wb_r_i    = 4'd0;
    pc_i      = 16'd0;
    test_reset;
    test_alu_directed;
    test_back_to_back;
    test_branch;
    test_random;
    test_mul;
    test_mul_reset;
    test_alu_directed;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
